// File: rtl/uart_sys_pkg.sv
// ---------------------------------------------------------------------------
// uart_sys_pkg
// Shared definitions for the UART command path: default opcodes, the command
// sequencer state encoding and a helper naming the states that run the
// inter-byte timer.
// ---------------------------------------------------------------------------
package uart_sys_pkg;

    localparam logic [7:0] OPC_WR_DEF = 8'hAA;
    localparam logic [7:0] OPC_RD_DEF = 8'hBB;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WR_ADDR  = 3'd1,
        ST_WR_DATA  = 3'd2,
        ST_WR_ISSUE = 3'd3,
        ST_RD_ADDR  = 3'd4,
        ST_RD_ISSUE = 3'd5,
        ST_RD_WAIT  = 3'd6,
        ST_TX_SEND  = 3'd7
    } state_t;

    // States in which a stalled byte stream or read response must time out.
    function automatic logic timed_state(input state_t s);
        return (s == ST_WR_ADDR) || (s == ST_WR_DATA) ||
               (s == ST_RD_ADDR) || (s == ST_RD_WAIT);
    endfunction

endpackage

// File: rtl/uart_rx_cmd_ctrl_frame_timer.sv
// ---------------------------------------------------------------------------
// frame_timer
// Clearable, enabled cycle counter with an expiry flag, used to bound the
// gap between bytes of a frame and the wait for read data.
//   i_clk      system clock
//   i_rst_n    synchronous active-low reset
//   i_clr      clear count to zero (has priority over i_en)
//   i_en       count this cycle
//   o_expired  count has reached TIMEOUT_CYC-1 while enabled
// ---------------------------------------------------------------------------
module frame_timer #(
    parameter int unsigned TIMEOUT_CYC = 4096
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expired
);

    localparam int unsigned W = $clog2(TIMEOUT_CYC);
    localparam logic [W-1:0] LAST = W'(TIMEOUT_CYC - 1);

    logic [W-1:0] r_cnt;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en && (r_cnt != LAST)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_expired = i_en && (r_cnt == LAST);

endmodule

// File: rtl/uart_rx_cmd_ctrl.sv
// ---------------------------------------------------------------------------
// uart_rx_cmd_ctrl
// Parses command frames from the UART receiver byte stream and drives the
// register file; read data is returned to the UART transmitter.
//   Write frame: OPC_WR, ADDR, DATA   Read frame: OPC_RD, ADDR
//   CLK, RST            clock, synchronous active-low reset
//   RX_P_DATA/RX_D_VLD  received byte and its one-cycle valid
//   WR_EN/RD_EN         one-cycle register-file strobes
//   ADDR/WR_DATA        register-file address and write data (held)
//   RD_DATA/RD_DATA_VLD register-file read data and its valid pulse
//   TX_P_DATA/TX_D_VLD  byte and one-cycle request to the transmitter
//   TX_BUSY             transmitter busy; no request issued while high
//   FRAME_ABORT         one-cycle pulse: timeout, bad address, dropped byte
// ---------------------------------------------------------------------------
module uart_rx_cmd_ctrl
    import uart_sys_pkg::*;
#(
    parameter int unsigned ADDR_W      = 4,
    parameter int unsigned TIMEOUT_CYC = 4096,
    parameter logic [7:0]  OPC_WR      = OPC_WR_DEF,
    parameter logic [7:0]  OPC_RD      = OPC_RD_DEF
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [7:0]        RX_P_DATA,
    input  logic              RX_D_VLD,
    output logic              WR_EN,
    output logic              RD_EN,
    output logic [ADDR_W-1:0] ADDR,
    output logic [7:0]        WR_DATA,
    input  logic [7:0]        RD_DATA,
    input  logic              RD_DATA_VLD,
    output logic [7:0]        TX_P_DATA,
    output logic              TX_D_VLD,
    input  logic              TX_BUSY,
    output logic              FRAME_ABORT
);

    state_t            r_state, w_next;
    logic              r_wr_en, r_rd_en, r_tx_vld, r_abort;
    logic [ADDR_W-1:0] r_addr;
    logic [7:0]        r_wdata, r_tx_data;

    logic w_accept, w_abort, w_tx_vld;
    logic w_cap_addr, w_cap_wdata, w_cap_rd;
    logic w_bad_addr, w_expired, w_timer_clr;

    assign w_bad_addr = (RX_P_DATA >> ADDR_W) != 8'd0;

    // Any state change or accepted byte restarts the inter-byte window.
    assign w_timer_clr = (w_next != r_state) || w_accept;

    frame_timer #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timer (
        .i_clk     (CLK),
        .i_rst_n   (RST),
        .i_clr     (w_timer_clr),
        .i_en      (timed_state(r_state)),
        .o_expired (w_expired)
    );

    always_comb begin
        w_next      = r_state;
        w_accept    = 1'b0;
        w_abort     = 1'b0;
        w_tx_vld    = 1'b0;
        w_cap_addr  = 1'b0;
        w_cap_wdata = 1'b0;
        w_cap_rd    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (RX_D_VLD) begin
                    if (RX_P_DATA == OPC_WR) begin
                        w_accept = 1'b1;
                        w_next   = ST_WR_ADDR;
                    end else if (RX_P_DATA == OPC_RD) begin
                        w_accept = 1'b1;
                        w_next   = ST_RD_ADDR;
                    end
                end
            end
            ST_WR_ADDR, ST_RD_ADDR: begin
                // A byte arriving in the expiry cycle takes precedence.
                if (RX_D_VLD) begin
                    w_accept = 1'b1;
                    if (w_bad_addr) begin
                        w_abort = 1'b1;
                        w_next  = ST_IDLE;
                    end else begin
                        w_cap_addr = 1'b1;
                        w_next     = (r_state == ST_WR_ADDR) ? ST_WR_DATA : ST_RD_ISSUE;
                    end
                end else if (w_expired) begin
                    w_abort = 1'b1;
                    w_next  = ST_IDLE;
                end
            end
            ST_WR_DATA: begin
                if (RX_D_VLD) begin
                    w_accept    = 1'b1;
                    w_cap_wdata = 1'b1;
                    w_next      = ST_WR_ISSUE;
                end else if (w_expired) begin
                    w_abort = 1'b1;
                    w_next  = ST_IDLE;
                end
            end
            ST_WR_ISSUE: begin
                w_abort = RX_D_VLD;
                w_next  = ST_IDLE;
            end
            ST_RD_ISSUE: begin
                w_abort = RX_D_VLD;
                if (RD_DATA_VLD) begin
                    w_cap_rd = 1'b1;
                    w_next   = ST_TX_SEND;
                end else begin
                    w_next = ST_RD_WAIT;
                end
            end
            ST_RD_WAIT: begin
                w_abort = RX_D_VLD;
                if (RD_DATA_VLD) begin
                    w_cap_rd = 1'b1;
                    w_next   = ST_TX_SEND;
                end else if (w_expired) begin
                    w_abort = 1'b1;
                    w_next  = ST_IDLE;
                end
            end
            ST_TX_SEND: begin
                w_abort = RX_D_VLD;
                if (!TX_BUSY) begin
                    w_tx_vld = 1'b1;
                    w_next   = ST_IDLE;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // Strobes are registered from the next state so they coincide with
    // the cycle spent in the issuing state.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            r_state   <= ST_IDLE;
            r_wr_en   <= 1'b0;
            r_rd_en   <= 1'b0;
            r_tx_vld  <= 1'b0;
            r_abort   <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_tx_data <= '0;
        end else begin
            r_state  <= w_next;
            r_wr_en  <= (w_next == ST_WR_ISSUE);
            r_rd_en  <= (w_next == ST_RD_ISSUE);
            r_tx_vld <= w_tx_vld;
            r_abort  <= w_abort;
            if (w_cap_addr)  r_addr    <= RX_P_DATA[ADDR_W-1:0];
            if (w_cap_wdata) r_wdata   <= RX_P_DATA;
            if (w_cap_rd)    r_tx_data <= RD_DATA;
        end
    end

    assign WR_EN       = r_wr_en;
    assign RD_EN       = r_rd_en;
    assign ADDR        = r_addr;
    assign WR_DATA     = r_wdata;
    assign TX_P_DATA   = r_tx_data;
    assign TX_D_VLD    = r_tx_vld;
    assign FRAME_ABORT = r_abort;

endmodule

// File: tb/tb_uart_rx_cmd_ctrl.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_cmd_ctrl
// Frame-level bench: each frame is described as per-edge input tables, the
// expected output events (cycle, address, data) are derived from the frame
// rules, and a monitor records the events the design actually produced.
// ---------------------------------------------------------------------------
module tb_uart_rx_cmd_ctrl;

    localparam int unsigned TMO = 16;
    localparam int          NS  = 128;

    logic       CLK = 1'b0;
    logic       RST;
    logic [7:0] RX_P_DATA;
    logic       RX_D_VLD;
    logic       WR_EN, RD_EN, TX_D_VLD, FRAME_ABORT;
    logic [3:0] ADDR;
    logic [7:0] WR_DATA, RD_DATA, TX_P_DATA;
    logic       RD_DATA_VLD, TX_BUSY;

    always #5 CLK = ~CLK;

    uart_rx_cmd_ctrl #(
        .ADDR_W      (4),
        .TIMEOUT_CYC (TMO),
        .OPC_WR      (8'hAA),
        .OPC_RD      (8'hBB)
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .RX_P_DATA   (RX_P_DATA),
        .RX_D_VLD    (RX_D_VLD),
        .WR_EN       (WR_EN),
        .RD_EN       (RD_EN),
        .ADDR        (ADDR),
        .WR_DATA     (WR_DATA),
        .RD_DATA     (RD_DATA),
        .RD_DATA_VLD (RD_DATA_VLD),
        .TX_P_DATA   (TX_P_DATA),
        .TX_D_VLD    (TX_D_VLD),
        .TX_BUSY     (TX_BUSY),
        .FRAME_ABORT (FRAME_ABORT)
    );

    // Edge counter: after posedge number m, cyc == m.
    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct {
        int         t;
        logic [7:0] a;
        logic [7:0] d;
    } ev_t;

    ev_t obs_wr[$], exp_wr[$], obs_rd[$], exp_rd[$];
    ev_t obs_tx[$], exp_tx[$], obs_ab[$], exp_ab[$];

    function automatic ev_t mk(input int t, input logic [7:0] a, input logic [7:0] d);
        ev_t e;
        e.t = t;
        e.a = a;
        e.d = d;
        return e;
    endfunction

    always @(negedge CLK) begin
        if (WR_EN === 1'b1)       obs_wr.push_back(mk(cyc, {4'h0, ADDR}, WR_DATA));
        if (RD_EN === 1'b1)       obs_rd.push_back(mk(cyc, {4'h0, ADDR}, 8'h00));
        if (TX_D_VLD === 1'b1)    obs_tx.push_back(mk(cyc, 8'h00, TX_P_DATA));
        if (FRAME_ABORT === 1'b1) obs_ab.push_back(mk(cyc, 8'h00, 8'h00));
    end

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cmp_q(input string tag, input ev_t o[$], input ev_t e[$],
                         input bit use_a, input bit use_d);
        chk({tag, ".count"}, o.size(), e.size());
        for (int i = 0; i < e.size() && i < o.size(); i++) begin
            chk($sformatf("%s[%0d].cycle", tag, i), o[i].t, e[i].t);
            if (use_a) chk($sformatf("%s[%0d].addr", tag, i), o[i].a, e[i].a);
            if (use_d) chk($sformatf("%s[%0d].data", tag, i), o[i].d, e[i].d);
        end
    endtask

    task automatic check_frame(input string tag);
        cmp_q({tag, ".wr"}, obs_wr, exp_wr, 1'b1, 1'b1);
        cmp_q({tag, ".rd"}, obs_rd, exp_rd, 1'b1, 1'b0);
        cmp_q({tag, ".tx"}, obs_tx, exp_tx, 1'b0, 1'b1);
        cmp_q({tag, ".abort"}, obs_ab, exp_ab, 1'b0, 1'b0);
        obs_wr.delete(); exp_wr.delete(); obs_rd.delete(); exp_rd.delete();
        obs_tx.delete(); exp_tx.delete(); obs_ab.delete(); exp_ab.delete();
    endtask

    // Per-edge stimulus tables, indexed by offset from the frame's first edge.
    bit         s_vld[NS];
    bit         s_rdv[NS];
    bit         s_busy[NS];
    logic [7:0] s_byte[NS];
    logic [7:0] s_rdd[NS];

    task automatic clr_stim();
        for (int i = 0; i < NS; i++) begin
            s_vld[i] = 1'b0; s_rdv[i] = 1'b0; s_busy[i] = 1'b0;
            s_byte[i] = 8'h00; s_rdd[i] = 8'h00;
        end
    endtask

    task automatic set_idle();
        RX_D_VLD    = 1'b0;
        RX_P_DATA   = 8'($urandom);
        RD_DATA_VLD = 1'b0;
        RD_DATA     = 8'($urandom);
        TX_BUSY     = 1'b0;
    endtask

    task automatic run_stim(input int n, output int base);
        base = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge CLK);
            if (i == 0) base = cyc + 1;
            RX_D_VLD    = s_vld[i];
            RX_P_DATA   = s_vld[i] ? s_byte[i] : 8'($urandom);
            RD_DATA_VLD = s_rdv[i];
            RD_DATA     = s_rdv[i] ? s_rdd[i] : 8'($urandom);
            TX_BUSY     = s_busy[i];
        end
        @(negedge CLK);
        set_idle();
        #1;
    endtask

    // Write frame with byte gaps g1, g2 (each <= TMO): WR_EN in the cycle
    // after the data byte is sampled.
    task automatic do_write(input logic [3:0] a, input logic [7:0] d,
                            input int g1, input int g2);
        int base;
        clr_stim();
        s_vld[0] = 1'b1;       s_byte[0] = 8'hAA;
        s_vld[g1] = 1'b1;      s_byte[g1] = {4'h0, a};
        s_vld[g1+g2] = 1'b1;   s_byte[g1+g2] = d;
        run_stim(g1 + g2 + 3, base);
        exp_wr.push_back(mk(base + g1 + g2, {4'h0, a}, d));
    endtask

    // Read frame: response lat edges after the address byte, TX_BUSY high
    // for busy_n edges after capture, optional stray byte at addr+drop_at.
    task automatic do_read(input logic [3:0] a, input logic [7:0] d, input int g1,
                           input int lat, input int busy_n, input int drop_at);
        int base, ka, kr;
        ka = g1;
        kr = ka + lat;
        clr_stim();
        s_vld[0] = 1'b1;  s_byte[0] = 8'hBB;
        s_vld[ka] = 1'b1; s_byte[ka] = {4'h0, a};
        s_rdv[kr] = 1'b1; s_rdd[kr] = d;
        for (int b = 1; b <= busy_n; b++) s_busy[kr+b] = 1'b1;
        if (drop_at > 0) begin
            s_vld[ka+drop_at] = 1'b1;
            s_byte[ka+drop_at] = 8'h77;
        end
        run_stim(kr + busy_n + 4, base);
        exp_rd.push_back(mk(base + ka, {4'h0, a}, 8'h00));
        exp_tx.push_back(mk(base + kr + busy_n + 1, 8'h00, d));
        if (drop_at > 0) exp_ab.push_back(mk(base + ka + drop_at, 8'h00, 8'h00));
    endtask

    task automatic do_junk(input logic [7:0] b, input bit rdv);
        int base;
        clr_stim();
        s_vld[0] = 1'b1; s_byte[0] = b;
        s_rdv[1] = rdv;  s_rdd[1] = 8'hE7;
        run_stim(3, base);
    endtask

    task automatic do_badaddr(input logic [7:0] op, input logic [7:0] bad, input int g1);
        int base;
        clr_stim();
        s_vld[0] = 1'b1;  s_byte[0] = op;
        s_vld[g1] = 1'b1; s_byte[g1] = bad;
        run_stim(g1 + 3, base);
        exp_ab.push_back(mk(base + g1, 8'h00, 8'h00));
    endtask

    // kind 0: AA alone, 1: AA+addr, 2: BB alone, 3: BB+addr with no response
    // (a late response after the abort must be ignored).
    task automatic do_timeout(input int kind, input int g1, input logic [3:0] a);
        int base;
        clr_stim();
        s_vld[0] = 1'b1;
        s_byte[0] = (kind < 2) ? 8'hAA : 8'hBB;
        if (kind == 1 || kind == 3) begin
            s_vld[g1] = 1'b1; s_byte[g1] = {4'h0, a};
        end
        if (kind == 3) begin
            s_rdv[g1+TMO+3] = 1'b1; s_rdd[g1+TMO+3] = 8'h99;
        end
        run_stim(g1 + TMO + 6, base);
        case (kind)
            0, 2: exp_ab.push_back(mk(base + TMO, 8'h00, 8'h00));
            1:    exp_ab.push_back(mk(base + g1 + TMO, 8'h00, 8'h00));
            default: begin
                exp_rd.push_back(mk(base + g1, {4'h0, a}, 8'h00));
                exp_ab.push_back(mk(base + g1 + 1 + TMO, 8'h00, 8'h00));
            end
        endcase
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".WR_EN"}, WR_EN, 0);
        chk({tag, ".RD_EN"}, RD_EN, 0);
        chk({tag, ".ADDR"}, ADDR, 0);
        chk({tag, ".WR_DATA"}, WR_DATA, 0);
        chk({tag, ".TX_P_DATA"}, TX_P_DATA, 0);
        chk({tag, ".TX_D_VLD"}, TX_D_VLD, 0);
        chk({tag, ".FRAME_ABORT"}, FRAME_ABORT, 0);
    endtask

    initial begin
        int base;
        RST = 1'b0;
        set_idle();
        repeat (3) @(negedge CLK);
        #1;
        chk_all_zero("reset");
        RST = 1'b1;
        obs_wr.delete(); obs_rd.delete(); obs_tx.delete(); obs_ab.delete();

        // Write with bytes arriving exactly in the expiry cycle.
        do_write(4'h5, 8'h3C, TMO, TMO);
        check_frame("wr_basic");
        do_read(4'hA, 8'h5A, 2, 4, 0, 0);
        check_frame("rd_basic");
        do_read(4'hA, 8'h5A, 2, 4, 50, 0);
        check_frame("rd_busy50");
        do_read(4'h6, 8'hC1, 3, 1, 0, 0);
        check_frame("rd_fast");
        do_read(4'h2, 8'h81, 1, TMO + 1, 0, 0);
        check_frame("rd_edge");
        do_timeout(1, 3, 4'h3);
        check_frame("wr_timeout");
        do_read(4'h3, 8'h42, 2, 3, 0, 0);
        check_frame("rd_after_to");
        do_junk(8'h11, 1'b1);
        do_badaddr(8'hAA, 8'h20, 2);
        check_frame("junk_badaddr");
        do_read(4'hA, 8'hC3, 2, 8, 0, 3);
        check_frame("rd_drop");
        do_timeout(3, 2, 4'h7);
        check_frame("rd_timeout");
        do_timeout(0, 1, 4'h0);
        do_timeout(2, 1, 4'h0);
        check_frame("op_timeout");

        for (int f = 0; f < 60; f++) begin
            int kind, lat, bn, drop;
            logic [7:0] b;
            kind = $urandom_range(0, 4);
            case (kind)
                0: do_write(4'($urandom), 8'($urandom),
                            $urandom_range(1, TMO), $urandom_range(1, TMO));
                1: begin
                    lat  = $urandom_range(1, TMO);
                    bn   = $urandom_range(0, 6);
                    drop = ($urandom_range(0, 1) == 1) ? $urandom_range(1, lat + bn + 1) : 0;
                    do_read(4'($urandom), 8'($urandom), $urandom_range(1, TMO), lat, bn, drop);
                end
                2: begin
                    b = 8'($urandom);
                    if (b == 8'hAA || b == 8'hBB) b = 8'h3C;
                    do_junk(b, 1'($urandom));
                end
                3: do_badaddr(($urandom_range(0, 1) == 1) ? 8'hAA : 8'hBB,
                              {4'($urandom_range(1, 15)), 4'($urandom)},
                              $urandom_range(1, TMO));
                default: do_timeout($urandom_range(0, 3), $urandom_range(1, TMO), 4'($urandom));
            endcase
            check_frame($sformatf("rand%0d", f));
        end

        // Reset in the middle of a write frame, after a read left TX_P_DATA set.
        do_read(4'hA, 8'h5A, 2, 2, 0, 0);
        check_frame("rd_pre_rst");
        clr_stim();
        s_vld[0] = 1'b1; s_byte[0] = 8'hAA;
        s_vld[2] = 1'b1; s_byte[2] = 8'h05;
        run_stim(4, base);
        chk("pre_rst.ADDR", ADDR, 4'h5);
        @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);
        #1;
        chk_all_zero("rst_mid");
        RST = 1'b1;
        clr_stim();
        s_vld[1] = 1'b1; s_byte[1] = 8'h3C;
        run_stim(TMO + 6, base);
        check_frame("post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
